// File: rtl/sha256_nonce_feeder_pkg.sv
// +--------------------------------------------------------------------------+
// | sha256_nonce_feeder_pkg : shared types and constants for the feeder      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package sha256_nonce_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] PAD_WORD    = 32'h8000_0000;
  localparam logic [31:0] LEN_WORD    = 32'h0000_0280;
  localparam int          PPL_LATENCY = 66;

  // Second 64-byte block of an 80-byte header: tail, nonce, padding, bit length.
  function automatic logic [511:0] build_chunk(input logic [95:0] tail_w,
                                               input logic [31:0] nonce_w);
    return {tail_w, nonce_w, PAD_WORD, 320'd0, LEN_WORD};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_hit_check.sv
// +--------------------------------------------------------------------------+
// | sha256_hit_check : registered difficulty compare, hit nonce and count    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module sha256_hit_check (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        valid_i,
  input  logic [31:0] hash_i,
  input  logic [31:0] mask_i,
  input  logic [31:0] nonce_i,
  output logic        found_o,
  output logic [31:0] found_nonce_o,
  output logic [15:0] hit_count_o
);

  logic        found_q;
  logic [31:0] found_nonce_q;
  logic [15:0] hit_count_q;
  logic        hit_w;

  always_comb begin
    hit_w = valid_i && ((hash_i & mask_i) == 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      found_q       <= 1'b0;
      found_nonce_q <= 32'd0;
      hit_count_q   <= 16'd0;
    end else begin
      found_q <= hit_w;
      if (hit_w) begin
        found_nonce_q <= nonce_i;
      end
      if (clr_i) begin
        hit_count_q <= 16'd0;
      end else if (hit_w && (hit_count_q != 16'hFFFF)) begin
        hit_count_q <= hit_count_q + 16'd1;
      end
    end
  end

  assign found_o       = found_q;
  assign found_nonce_o = found_nonce_q;
  assign hit_count_o   = hit_count_q;

endmodule

`default_nettype wire

// File: rtl/sha256_nonce_feeder.sv
// +--------------------------------------------------------------------------+
// | sha256_nonce_feeder : issues one nonce per cycle into a SHA-256 pipeline |
// | and tracks in-order results for difficulty hits.             Rev 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

module sha256_nonce_feeder
  import sha256_nonce_feeder_pkg::*;
#(
  parameter int INFLIGHT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [255:0] midstate,
  input  logic [95:0]  tail,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [31:0]  hit_mask,
  output logic         ppl_valid_o,
  output logic [255:0] ppl_init,
  output logic [511:0] ppl_chunk,
  input  logic         ppl_valid_i,
  input  logic [31:0]  ppl_hash_7,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [31:0]  found_nonce,
  output logic [15:0]  hit_count
);

  state_e                  state_q, state_d;
  logic [255:0]            init_q;
  logic [95:0]             tail_q;
  logic [31:0]             end_q, mask_q, issue_nonce_q, ret_nonce_q;
  logic [INFLIGHT_W-1:0]   inflight_q, inflight_d;
  logic                    valid_q;
  logic [511:0]            chunk_q;
  logic                    accept_w, issue_w, last_w, ret_w;

  always_comb begin
    accept_w = (state_q == ST_IDLE) && start;
    issue_w  = (state_q == ST_RUN) && !abort;
    last_w   = issue_w && (issue_nonce_q == end_q);
    ret_w    = ppl_valid_i && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (abort || last_w) state_d = ST_DRAIN;
      ST_DRAIN: if ((inflight_q == '0) && !ppl_valid_i) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  // Issue and return in the same cycle cancel out.
  always_comb begin
    inflight_d = inflight_q;
    if (issue_w && !ret_w) begin
      inflight_d = inflight_q + INFLIGHT_W'(1);
    end else if (!issue_w && ret_w) begin
      inflight_d = inflight_q - INFLIGHT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_q        <= '0;
      tail_q        <= '0;
      end_q         <= '0;
      mask_q        <= '0;
      issue_nonce_q <= '0;
      ret_nonce_q   <= '0;
      inflight_q    <= '0;
      valid_q       <= 1'b0;
      chunk_q       <= '0;
    end else begin
      inflight_q <= inflight_d;
      valid_q    <= issue_w;
      if (accept_w) begin
        init_q        <= midstate;
        tail_q        <= tail;
        end_q         <= nonce_end;
        mask_q        <= hit_mask;
        issue_nonce_q <= nonce_start;
        ret_nonce_q   <= nonce_start;
      end
      if (issue_w) begin
        chunk_q       <= build_chunk(tail_q, issue_nonce_q);
        issue_nonce_q <= issue_nonce_q + 32'd1;
      end
      if (ret_w) begin
        ret_nonce_q <= ret_nonce_q + 32'd1;
      end
    end
  end

  assign ppl_valid_o = valid_q;
  assign ppl_init    = init_q;
  assign ppl_chunk   = chunk_q;

  sha256_hit_check u_hit_check (
    .clk           (clk),
    .rst           (rst),
    .clr_i         (accept_w),
    .valid_i       (ret_w),
    .hash_i        (ppl_hash_7),
    .mask_i        (mask_q),
    .nonce_i       (ret_nonce_q),
    .found_o       (found),
    .found_nonce_o (found_nonce),
    .hit_count_o   (hit_count)
  );

endmodule

`default_nettype wire
